// File: rtl/serial_pkg.sv
// serial_pkg: shared types and sizing helpers for the serial operand loader.
// Optional feature macro: SERIAL_LOADER_SIGN_EXTEND_EN (adds one sign-repeat
// bit to every frame so the serial sum cannot overflow).
package serial_pkg;

    // Loader FSM states.
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Number of serial bits per frame for a given operand width.
    function automatic int frame_len(input int width);
`ifdef SERIAL_LOADER_SIGN_EXTEND_EN
        return width + 1;
`else
        return width;
`endif
    endfunction

    // Bit counter width: wide enough to hold values 0..frame_len.
    function automatic int cnt_width(input int width);
        return $clog2(frame_len(width) + 1);
    endfunction

endpackage

// File: rtl/serial_operand_loader_if.sv
// serial_operand_loader_if: operand handshake plus serial frame outputs.
// Handshake: a pair transfers on a rising edge where in_valid && in_ready;
// in_ready never depends on in_valid, and the producer holds op_a/op_b
// stable while in_valid is high and in_ready is low.
// Optional feature macro: SERIAL_LOADER_SIGN_EXTEND_EN (no effect on ports).
interface serial_operand_loader_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             a;
    logic             b;
    logic             first;
    logic             last;
    logic             busy;

    // Producer / observer side.
    modport master (
        output in_valid, op_a, op_b,
        input  in_ready, a, b, first, last, busy
    );

    // Loader side.
    modport slave (
        input  in_valid, op_a, op_b,
        output in_ready, a, b, first, last, busy
    );
endinterface

// File: rtl/piso_shift_reg.sv
// piso_shift_reg: parallel-load, shift-right register with LSB serial output.
// With SIGN_REPEAT set, the MSB is replicated on every shift, so a shift
// beyond WIDTH-1 keeps presenting the operand sign bit.
// Optional feature macro: SERIAL_LOADER_SIGN_EXTEND_EN (selected by the top).
module piso_shift_reg #(
    parameter int WIDTH       = 8,
    parameter bit SIGN_REPEAT = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic             clear,
    input  logic [WIDTH-1:0] din,
    output logic             dout
);
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] shifted;

    // Next value for a right shift; fill bit is 0 or the current MSB.
    always_comb begin
        shifted = data_q >> 1;
        if (SIGN_REPEAT) begin
            shifted[WIDTH-1] = data_q[WIDTH-1];
        end
    end

    // Load has priority over clear, clear over shift.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q <= '0;
        end else if (load) begin
            data_q <= din;
        end else if (clear) begin
            data_q <= '0;
        end else if (shift) begin
            data_q <= shifted;
        end
    end

    assign dout = data_q[0];
endmodule

// File: rtl/serial_operand_loader.sv
// serial_operand_loader: accepts an operand pair via valid/ready and shifts
// both operands out LSB-first, one bit per clock, with first/last markers.
// Optional feature macro: SERIAL_LOADER_SIGN_EXTEND_EN (frame = WIDTH+1
// bits, the extra bit repeating each operand MSB).
module serial_operand_loader
    import serial_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    serial_operand_loader_if.slave   bus,
    output state_t                   state_dbg
);
    localparam int L  = frame_len(WIDTH);
    localparam int CW = cnt_width(WIDTH);

`ifdef SERIAL_LOADER_SIGN_EXTEND_EN
    localparam bit SIGN_REPEAT = 1'b1;
`else
    localparam bit SIGN_REPEAT = 1'b0;
`endif

    state_t         state, state_n;
    logic [CW-1:0]  count, count_n;
    logic           is_last;
    logic           ready;
    logic           load;
    logic           shift;
    logic           clear;
    logic           busy_q, first_q, last_q;
    logic           busy_n, first_n, last_n;

    // State and bit counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= state_n;
            count <= count_n;
        end
    end

    // Next state: start on transfer, advance per bit, reload or stop at the end.
    always_comb begin
        state_n = state;
        count_n = count;
        unique case (state)
            IDLE: begin
                if (load) begin
                    state_n = SHIFT;
                    count_n = '0;
                end
            end
            SHIFT: begin
                if (is_last) begin
                    count_n = '0;
                    state_n = load ? SHIFT : IDLE;
                end else begin
                    count_n = count + CW'(1);
                end
            end
            default: begin
                state_n = IDLE;
                count_n = '0;
            end
        endcase
    end

    // Handshake, shift-register controls and next values of the marker flops.
    always_comb begin
        is_last = (state == SHIFT) && (count == CW'(L - 1));
        ready   = (state == IDLE) || is_last;
        load    = bus.in_valid && ready;
        shift   = (state == SHIFT) && !is_last;
        clear   = is_last && !load;
        busy_n  = (state_n == SHIFT);
        first_n = (state_n == SHIFT) && (count_n == '0);
        last_n  = (state_n == SHIFT) && (count_n == CW'(L - 1));
    end

    // Registered frame markers so the adder sees them stable all cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q  <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            busy_q  <= busy_n;
            first_q <= first_n;
            last_q  <= last_n;
        end
    end

    piso_shift_reg #(
        .WIDTH       (WIDTH),
        .SIGN_REPEAT (SIGN_REPEAT)
    ) u_shift_a (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .shift (shift),
        .clear (clear),
        .din   (bus.op_a),
        .dout  (bus.a)
    );

    piso_shift_reg #(
        .WIDTH       (WIDTH),
        .SIGN_REPEAT (SIGN_REPEAT)
    ) u_shift_b (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .shift (shift),
        .clear (clear),
        .din   (bus.op_b),
        .dout  (bus.b)
    );

    assign bus.in_ready = ready;
    assign bus.busy     = busy_q;
    assign bus.first    = first_q;
    assign bus.last     = last_q;
    assign state_dbg    = state;
endmodule

// File: tb/tb_serial_operand_loader.sv
// tb_serial_operand_loader: directed bench for a WIDTH=4 and a WIDTH=1 loader.
// Optional feature macro: SERIAL_LOADER_SIGN_EXTEND_EN (frame lengths and
// expected vectors follow it).
module tb_serial_operand_loader;
    import serial_pkg::*;

`ifdef SERIAL_LOADER_SIGN_EXTEND_EN
    localparam int L4 = 5;
    localparam int L1 = 2;
`else
    localparam int L4 = 4;
    localparam int L1 = 1;
`endif

    logic   clk = 1'b0;
    logic   reset4 = 1'b1;
    logic   reset1 = 1'b1;
    state_t state4, state1;
    int     n_checks = 0;
    int     n_fails  = 0;

    serial_operand_loader_if #(.WIDTH(4)) bus4 ();
    serial_operand_loader_if #(.WIDTH(1)) bus1 ();

    serial_operand_loader #(.WIDTH(4)) dut4 (
        .clk       (clk),
        .reset     (reset4),
        .bus       (bus4.slave),
        .state_dbg (state4)
    );

    serial_operand_loader #(.WIDTH(1)) dut1 (
        .clk       (clk),
        .reset     (reset1),
        .bus       (bus1.slave),
        .state_dbg (state1)
    );

    // Clock.
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Idle outputs of the 4-bit loader.
    task automatic chk_idle4(input string tag);
        chk({tag, "_a"},     bus4.a,        1'b0);
        chk({tag, "_b"},     bus4.b,        1'b0);
        chk({tag, "_first"}, bus4.first,    1'b0);
        chk({tag, "_last"},  bus4.last,     1'b0);
        chk({tag, "_busy"},  bus4.busy,     1'b0);
        chk({tag, "_ready"}, bus4.in_ready, 1'b1);
    endtask

    // Checks one 4-bit frame; ea/eb hold the expected bit for cycle i at [i].
    // mode 0: plain; mode 1: pulse in_valid with other data in non-final
    // cycles; mode 2: leave the next pair pending for a back-to-back reload.
    task automatic check_frame(input string tag, input logic [4:0] ea,
                               input logic [4:0] eb, input int mode);
        for (int i = 0; i < L4; i++) begin
            @(negedge clk);
            chk($sformatf("%s_a%0d", tag, i),     bus4.a,        ea[i]);
            chk($sformatf("%s_b%0d", tag, i),     bus4.b,        eb[i]);
            chk($sformatf("%s_first%0d", tag, i), bus4.first,    i == 0);
            chk($sformatf("%s_last%0d", tag, i),  bus4.last,     i == L4 - 1);
            chk($sformatf("%s_busy%0d", tag, i),  bus4.busy,     1'b1);
            chk($sformatf("%s_ready%0d", tag, i), bus4.in_ready, i == L4 - 1);
            if (mode == 1) begin
                bus4.in_valid = (i < L4 - 1);
                bus4.op_a     = 4'hC;
                bus4.op_b     = 4'h9;
            end
        end
    endtask

    // Present a pair on the 4-bit loader and let it transfer at the next edge.
    task automatic send4(input logic [3:0] va, input logic [3:0] vb, input bit keep);
        @(negedge clk);
        bus4.in_valid = 1'b1;
        bus4.op_a     = va;
        bus4.op_b     = vb;
        @(posedge clk);
        #1;
        if (!keep) begin
            bus4.in_valid = 1'b0;
            bus4.op_a     = 4'(~va);
            bus4.op_b     = 4'(~vb);
        end
    endtask

    initial begin
        bus4.in_valid = 1'b0;
        bus4.op_a     = '0;
        bus4.op_b     = '0;
        bus1.in_valid = 1'b0;
        bus1.op_a     = '0;
        bus1.op_b     = '0;

        // Reset values while reset is held.
        @(posedge clk);
        @(negedge clk);
        chk_idle4("rst4");
        chk("rst4_state", state4 == IDLE, 1'b1);
        chk("rst1_busy",  bus1.busy,     1'b0);
        chk("rst1_ready", bus1.in_ready, 1'b1);
        reset4 = 1'b0;
        reset1 = 1'b0;
        @(negedge clk);
        chk_idle4("post_rst");

        // Basic frame: 0101 / 0011.
        send4(4'b0101, 4'b0011, 1'b0);
        check_frame("basic", 5'b00101, 5'b00011, 0);
        @(negedge clk);
        chk_idle4("basic_end");

        // Back-to-back frames: (5,3) then (F,1) with in_valid held.
        send4(4'h5, 4'h3, 1'b1);
        bus4.op_a = 4'hF;
        bus4.op_b = 4'h1;
        check_frame("b2b_f1", 5'b00101, 5'b00011, 2);
        @(posedge clk);
        #1;
        bus4.in_valid = 1'b0;
        bus4.op_a     = 4'h0;
        bus4.op_b     = 4'h0;
        check_frame("b2b_f2", 5'b11111, 5'b00001, 0);
        @(negedge clk);
        chk_idle4("b2b_end");

        // Stall: in_valid pulsed mid-frame must not disturb the frame.
        send4(4'b0110, 4'b1001, 1'b0);
        check_frame("stall", 5'b00110, 5'b11001, 1);
        @(negedge clk);
        chk_idle4("stall_end");
        chk("stall_state", state4 == IDLE, 1'b1);

        // Sign operands: 1010 / 0110.
        send4(4'b1010, 4'b0110, 1'b0);
        check_frame("sign", 5'b11010, 5'b00110, 0);
        @(negedge clk);
        chk_idle4("sign_end");

        // Reset mid-frame at cycle k+2.
        send4(4'b0101, 4'b0011, 1'b0);
        @(negedge clk);
        chk("mid_a0", bus4.a, 1'b1);
        @(negedge clk);
        chk("mid_a1", bus4.a, 1'b0);
        @(posedge clk);
        #1;
        chk("mid_a2",    bus4.a,    1'b1);
        chk("mid_busy2", bus4.busy, 1'b1);
        reset4 = 1'b1;
        #1;
        chk_idle4("mid_rst");
        @(negedge clk);
        reset4 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_idle4($sformatf("mid_after%0d", i));
        end

        // WIDTH=1 frame: op_a=1, op_b=0.
        @(negedge clk);
        bus1.in_valid = 1'b1;
        bus1.op_a     = 1'b1;
        bus1.op_b     = 1'b0;
        @(posedge clk);
        #1;
        bus1.in_valid = 1'b0;
        bus1.op_a     = 1'b0;
        bus1.op_b     = 1'b1;
        for (int i = 0; i < L1; i++) begin
            @(negedge clk);
            chk($sformatf("w1_a%0d", i),     bus1.a,     1'b1);
            chk($sformatf("w1_b%0d", i),     bus1.b,     1'b0);
            chk($sformatf("w1_first%0d", i), bus1.first, i == 0);
            chk($sformatf("w1_last%0d", i),  bus1.last,  i == L1 - 1);
            chk($sformatf("w1_busy%0d", i),  bus1.busy,  1'b1);
        end
        @(negedge clk);
        chk("w1_end_a",     bus1.a,        1'b0);
        chk("w1_end_busy",  bus1.busy,     1'b0);
        chk("w1_end_last",  bus1.last,     1'b0);
        chk("w1_end_ready", bus1.in_ready, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
